pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Collects stall requests from ID (load-use), EX (multi-cycle divide) and MEM (bus wait).
- Drives the 6-bit stall vector consumed by pc_reg and every pipeline register (if_id … mem_wb), plus a flush pulse.
- Owns a divide-latency counter and a bus-timeout counter, so stall duration is sequenced here, not by requesters.

Parameters:
- DIV_CYCLES, 32, EX-stage stall cycles per divide, counted from the start cycle inclusive; must be ≥2.
- BUS_TIMEOUT, 255, max MEM wait cycles before abort; 8-bit counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- id_stallreq  in  1  load-use hazard from ID; level, combinational
- ex_div_start  in  1  one-cycle pulse: divide issued in EX this cycle
- mem_req  in  1  MEM stage bus access pending
- mem_ack  in  1  bus completes access this cycle
- flush_req  in  1  exception/eret flush from MEM-stage exception logic
- stall  out  6  bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 wb; 1 = Stop
- flush  out  1  registered one-cycle flush to all pipeline registers
- div_busy  out  1  divide sequence in progress
- div_done  out  1  one-cycle pulse, last divide cycle; EX latches result
- bus_err  out  1  one-cycle registered pulse on bus timeout

Behaviour:
- Reset (async, rst=1): state IDLE; counters 0; stall=6'b000000; flush, div_busy, div_done, bus_err = 0.
- FSM states: IDLE, DIV_BUSY, MEM_WAIT. MEM_WAIT may coexist with a running divide counter: div_cnt runs independently while nonzero.
- Stall encoding (combinational from state + inputs, highest-priority request wins):
  - flush_req=1 → 6'b000000.
  - MEM wait active (mem_req & !mem_ack, timeout not reached) → 6'b011111.
  - EX divide active (ex_div_start, or div_cnt ≠ 0 and not the last cycle) → 6'b001111.
  - id_stallreq → 6'b000111.
  - else → 6'b000000.
- Divide sequencing:
  - ex_div_start in IDLE loads div_cnt = DIV_CYCLES-1; div_busy=1 from the next cycle until div_cnt reaches 0.
  - div_done=1 (combinational) in the cycle div_cnt==1. EX stall released that same cycle, so the result advances at the next edge.
  - ex_div_start while div_busy=1 is ignored.
- MEM wait:
  - mem_req & !mem_ack → MEM_WAIT; tmo_cnt increments each wait cycle.
  - mem_ack → stall bit4..0 released that cycle; return to IDLE; tmo_cnt cleared.
  - tmo_cnt == BUS_TIMEOUT → stall released; bus_err=1 for exactly one cycle (registered); IDLE.
  - mem_req deasserted in MEM_WAIT → IDLE, no error.
- Flush:
  - flush_req=1 → flush=1 next cycle for one cycle; div_cnt and tmo_cnt cleared; state IDLE; div_done suppressed.
  - flush_req in the same cycle as mem_ack or the last divide cycle: flush wins; no div_done, no bus_err.
- Stall is never gated by clk. Requesters hold req levels until released; stall is glitch-free relative to registered state.

Test Plan:
- Reset mid-divide: ex_div_start, 5 cycles, rst=1 asynchronously → stall=0, div_busy=0 immediately (before next clk edge).
- id_stallreq=1 for 1 cycle, nothing else → stall=6'b000111 that cycle only; 0 after.
- ex_div_start with DIV_CYCLES=32 → stall=6'b001111 for exactly 31 cycles; div_done high in the 32nd cycle with stall=0 that cycle; div_busy falls after.
- mem_req=1, mem_ack at cycle 4, id_stallreq=1 throughout → stall=6'b011111 cycles 0–3; 6'b000111 at cycle 4; bus_err=0.
- mem_req=1, mem_ack never, BUS_TIMEOUT=255 → stall 6'b011111 for 255 cycles; bus_err pulse 1 cycle; stall=0 thereafter.
- Divide at cycle 10 of 32, flush_req=1 → stall=0 same cycle; flush=1 next cycle only; div_busy=0; no div_done ever.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - stall request / stall control bundle between pipeline stages and the sequencer
interface pipe_stall_ctrl_if;
  logic       id_stallreq;
  logic       ex_div_start;
  logic       mem_req;
  logic       mem_ack;
  logic       flush_req;
  logic [5:0] stall;
  logic       flush;
  logic       div_busy;
  logic       div_done;
  logic       bus_err;

  modport slave (
    input  id_stallreq, ex_div_start, mem_req, mem_ack, flush_req,
    output stall, flush, div_busy, div_done, bus_err
  );

  modport master (
    output id_stallreq, ex_div_start, mem_req, mem_ack, flush_req,
    input  stall, flush, div_busy, div_done, bus_err
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - central stall/flush sequencer with divide-latency and bus-timeout counters
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES  = 32,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stall_ctrl_if.slave bus
);

  localparam int DW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DIV_BUSY, MEM_WAIT} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt, div_cnt_nxt;
  logic [7:0]    tmo_cnt, tmo_cnt_nxt;
  logic          flush_q, bus_err_q, bus_err_nxt;
  logic          div_start, div_active, mem_wait, timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      tmo_cnt   <= '0;
      flush_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_cnt_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
      flush_q   <= bus.flush_req;
      bus_err_q <= bus_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    div_cnt_nxt  = div_cnt;
    tmo_cnt_nxt  = '0;
    bus_err_nxt  = 1'b0;
    bus.stall    = 6'b000000;
    bus.div_busy = (div_cnt != '0);
    bus.div_done = (div_cnt == DW'(1)) && !bus.flush_req;

    // A divide is accepted only when the counter is idle; re-issues mid-sequence are dropped.
    timeout    = (state == MEM_WAIT) && (tmo_cnt == 8'(BUS_TIMEOUT));
    div_start  = bus.ex_div_start && (div_cnt == '0);
    div_active = div_start || (div_cnt > DW'(1));
    mem_wait   = bus.mem_req && !bus.mem_ack && !timeout;

    if (bus.flush_req)     bus.stall = 6'b000000;
    else if (mem_wait)     bus.stall = 6'b011111;
    else if (div_active)   bus.stall = 6'b001111;
    else if (bus.id_stallreq) bus.stall = 6'b000111;

    if (div_start)            div_cnt_nxt = DW'(DIV_CYCLES - 1);
    else if (div_cnt != '0)   div_cnt_nxt = div_cnt - DW'(1);

    if (mem_wait) tmo_cnt_nxt = tmo_cnt + 8'd1;
    bus_err_nxt = timeout && bus.mem_req && !bus.mem_ack;

    if (bus.flush_req) begin
      div_cnt_nxt = '0;
      tmo_cnt_nxt = '0;
      bus_err_nxt = 1'b0;
      state_nxt   = IDLE;
    end else if (mem_wait) begin
      state_nxt = MEM_WAIT;
    end else if (div_cnt_nxt != '0) begin
      state_nxt = DIV_BUSY;
    end else begin
      state_nxt = IDLE;
    end
  end

  assign bus.flush   = flush_q;
  assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed bench with a cycle-level reference model for pipe_stall_ctrl
module tb_pipe_stall_ctrl;
  localparam int DIV = 32;
  localparam int TMO = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl #(.DIV_CYCLES(DIV), .BUS_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: divide tracked by its issue cycle, bus wait by length of the current wait run.
  int cyc = 0;
  int div_t0 = -1;
  int wait_run = 0;
  bit flush_pend = 0;
  bit err_pend = 0;

  always @(negedge clk) begin
    int  age;
    bit  busy_e, last_e, starting, div_stall, timed_out, mem_stall;
    logic [5:0] stall_e;
    if (rst) begin
      div_t0 = -1; wait_run = 0; flush_pend = 0; err_pend = 0;
      check("rst_stall", bus.stall, 0);
      check("rst_flush", bus.flush, 0);
      check("rst_div_busy", bus.div_busy, 0);
      check("rst_div_done", bus.div_done, 0);
      check("rst_bus_err", bus.bus_err, 0);
    end else begin
      age       = (div_t0 >= 0) ? cyc - div_t0 : -1;
      busy_e    = (age >= 1) && (age <= DIV - 1);
      last_e    = (age == DIV - 1);
      starting  = bus.ex_div_start && !busy_e;
      div_stall = starting || (busy_e && !last_e);
      timed_out = (wait_run == TMO);
      mem_stall = bus.mem_req && !bus.mem_ack && !timed_out;
      if (bus.flush_req)       stall_e = 6'b000000;
      else if (mem_stall)      stall_e = 6'b011111;
      else if (div_stall)      stall_e = 6'b001111;
      else if (bus.id_stallreq) stall_e = 6'b000111;
      else                     stall_e = 6'b000000;
      check("stall", bus.stall, stall_e);
      check("div_busy", bus.div_busy, busy_e);
      check("div_done", bus.div_done, last_e && !bus.flush_req);
      check("flush", bus.flush, flush_pend);
      check("bus_err", bus.bus_err, err_pend);
      flush_pend = bus.flush_req;
      err_pend   = timed_out && bus.mem_req && !bus.mem_ack && !bus.flush_req;
      wait_run   = (mem_stall && !bus.flush_req) ? wait_run + 1 : 0;
      if (bus.flush_req) div_t0 = -1;
      else if (starting) div_t0 = cyc;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, at, cnt;
    bus.id_stallreq = 0; bus.ex_div_start = 0; bus.mem_req = 0;
    bus.mem_ack = 0; bus.flush_req = 0;
    repeat (3) step();
    rst = 0;
    step();

    // load-use stall for one cycle
    bus.id_stallreq = 1;
    #1 check("id_stall_on", bus.stall, 6'b000111);
    step(); bus.id_stallreq = 0;
    #1 check("id_stall_off", bus.stall, 6'b000000);
    step();

    // full divide, with a re-issue mid-sequence that must be ignored
    bus.ex_div_start = 1; n = 0; at = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.stall == 6'b001111) n++;
      if (bus.div_done) begin
        at = i;
        check("div_done_stall", bus.stall, 6'b000000);
      end
      if (i == 31) check("div_busy_last", bus.div_busy, 1);
      if (i == 32) check("div_busy_after", bus.div_busy, 0);
      step();
      bus.ex_div_start = (i == 9);
    end
    check("div_stall_cycles", n, 31);
    check("div_done_cycle", at, 31);

    // bus wait with ack on cycle 4, load-use held throughout
    bus.mem_req = 1; bus.id_stallreq = 1;
    for (int i = 0; i < 5; i++) begin
      #1 check("mem_ack_stall", bus.stall, (i < 4) ? 6'b011111 : 6'b000111);
      step();
      if (i == 3) bus.mem_ack = 1;
    end
    bus.mem_req = 0; bus.mem_ack = 0; bus.id_stallreq = 0;
    #1 check("mem_ack_no_err", bus.bus_err, 0);
    step();

    // bus timeout
    bus.mem_req = 1; n = 0; at = -1; cnt = 0;
    for (int i = 0; i < 262; i++) begin
      #1;
      if (bus.stall == 6'b011111) n++;
      if (bus.bus_err) begin at = i; cnt++; end
      if (i >= 255) check("tmo_stall_released", bus.stall, 6'b000000);
      step();
      if (i == 255) bus.mem_req = 0;
    end
    check("tmo_stall_cycles", n, 255);
    check("tmo_err_cycle", at, 256);
    check("tmo_err_count", cnt, 1);

    // flush at cycle 10 of a divide
    bus.ex_div_start = 1; n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.div_done) n++;
      if (i == 10) check("flush_stall", bus.stall, 6'b000000);
      if (i == 11) begin
        check("flush_pulse", bus.flush, 1);
        check("flush_div_busy", bus.div_busy, 0);
      end
      if (i == 12) check("flush_once", bus.flush, 0);
      step();
      bus.ex_div_start = 0;
      bus.flush_req = (i == 9);
    end
    check("flush_no_done", n, 0);

    // flush on the last divide cycle suppresses div_done
    bus.ex_div_start = 1; n = 0;
    for (int i = 0; i < 34; i++) begin
      #1;
      if (bus.div_done) n++;
      step();
      bus.ex_div_start = 0;
      bus.flush_req = (i == 30);
    end
    bus.flush_req = 0;
    check("flush_last_no_done", n, 0);

    // asynchronous reset mid-divide
    bus.ex_div_start = 1;
    step(); bus.ex_div_start = 0;
    repeat (5) step();
    #1 check("pre_rst_busy", bus.div_busy, 1);
    rst = 1;
    #1;
    check("async_rst_stall", bus.stall, 6'b000000);
    check("async_rst_busy", bus.div_busy, 0);
    repeat (2) step();
    rst = 0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
